// File: rtl/dmem_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_stall_unit_pkg
//  Description : Shared CPU constants for the data-memory stall unit: data
//                word width, data-memory FSM state encoding and the read
//                value returned for out-of-range loads.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_stall_unit_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] RD_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_DONE = 2'd2
    } dm_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH x WORD_W data storage, synchronous write port and
//                asynchronous read port sharing one address. No reset: the
//                contents survive a CPU reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_stall_unit_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Store the word at the rising edge when write is enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule
`default_nettype wire

// File: rtl/dmem_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_stall_unit
//  Description : Multi-cycle data memory for the MEM stage. Latches the
//                request, holds the pipeline with stall until the access is
//                done, delivers load data in the DONE cycle and flags
//                out-of-range addresses with a one-cycle addr_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_stall_unit
    import dmem_stall_unit_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wr_data,
    input  logic              mem_reIn,
    input  logic              mem_weIn,
    output logic [WORD_W-1:0] mem_rd_data,
    output logic              stall,
    output logic              addr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD_W:0] DEPTH_EXT = (WORD_W + 1)'(DEPTH);

    logic              req;
    logic              in_range;
    logic              arr_we;
    logic [AW-1:0]     arr_addr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;

    // A store wins when both enables are set, so req only needs the OR
    assign req      = mem_reIn | mem_weIn;
    assign in_range = {1'b0, mem_addr} < DEPTH_EXT;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    generate
        if (LATENCY == 0) begin : g_comb
            // Single-cycle memory: live inputs go straight to the array
            assign arr_we      = mem_weIn & in_range;
            assign arr_addr    = mem_addr[AW-1:0];
            assign arr_wdata   = mem_wr_data;
            assign mem_rd_data = in_range ? arr_rdata : RD_DEFAULT;
            assign stall       = 1'b0;
            assign addr_err    = req & ~in_range;
        end else begin : g_fsm
            localparam logic [CNT_W-1:0] CNT_INIT =
                CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

            dm_state_e         state_q, state_d;
            logic [CNT_W-1:0]  cnt_q, cnt_d;
            logic [AW-1:0]     addr_q, addr_d;
            logic [WORD_W-1:0] data_q, data_d;
            logic              wr_q, wr_d;
            logic              range_q, range_d;
            logic [WORD_W-1:0] rd_q, rd_d;

            logic              access;
            logic [AW-1:0]     acc_addr;
            logic [WORD_W-1:0] acc_data;
            logic              acc_wr;
            logic              acc_range;

            // Select which request (live for LATENCY 1, latched otherwise) hits the array this edge
            always_comb begin
                access    = 1'b0;
                acc_addr  = addr_q;
                acc_data  = data_q;
                acc_wr    = wr_q;
                acc_range = range_q;
                if (state_q == DM_IDLE && req && LATENCY == 1) begin
                    access    = 1'b1;
                    acc_addr  = mem_addr[AW-1:0];
                    acc_data  = mem_wr_data;
                    acc_wr    = mem_weIn;
                    acc_range = in_range;
                end else if (state_q == DM_WAIT && cnt_q == '0) begin
                    access    = 1'b1;
                end
            end

            assign arr_we    = access & acc_wr & acc_range;
            assign arr_addr  = acc_addr;
            assign arr_wdata = acc_data;

            // Next-state, request latches, read capture and stall
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                addr_d  = addr_q;
                data_d  = data_q;
                wr_d    = wr_q;
                range_d = range_q;
                rd_d    = rd_q;
                stall   = 1'b0;
                case (state_q)
                    DM_IDLE: begin
                        if (req) begin
                            stall   = 1'b1;
                            addr_d  = mem_addr[AW-1:0];
                            data_d  = mem_wr_data;
                            wr_d    = mem_weIn;
                            range_d = in_range;
                            if (LATENCY == 1) begin
                                state_d = DM_DONE;
                            end else begin
                                state_d = DM_WAIT;
                                cnt_d   = CNT_INIT;
                            end
                        end
                    end
                    DM_WAIT: begin
                        stall = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = DM_DONE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    DM_DONE: begin
                        state_d = DM_IDLE;
                    end
                    default: begin
                        state_d = DM_IDLE;
                    end
                endcase
                if (access && !acc_wr) begin
                    rd_d = acc_range ? arr_rdata : RD_DEFAULT;
                end
            end

            // State and latch registers with synchronous active-low reset
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= DM_IDLE;
                    cnt_q   <= '0;
                    addr_q  <= '0;
                    data_q  <= '0;
                    wr_q    <= 1'b0;
                    range_q <= 1'b1;
                    rd_q    <= RD_DEFAULT;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    addr_q  <= addr_d;
                    data_q  <= data_d;
                    wr_q    <= wr_d;
                    range_q <= range_d;
                    rd_q    <= rd_d;
                end
            end

            assign mem_rd_data = rd_q;
            assign addr_err    = (state_q == DM_DONE) & ~range_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dmem_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_stall_unit
//  Description : Directed bench for dmem_stall_unit. Instance k runs with
//                LATENCY = k (k = 0..4), all sharing one clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_stall_unit;

    localparam int N = 5;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr  [N];
    logic [15:0] wdata [N];
    logic        re    [N];
    logic        we    [N];
    logic [15:0] rd    [N];
    logic        stall [N];
    logic        err   [N];

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_dut
        dmem_stall_unit #(
            .DEPTH   (256),
            .LATENCY (i),
            .CNT_W   (4)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .mem_addr    (addr[i]),
            .mem_wr_data (wdata[i]),
            .mem_reIn    (re[i]),
            .mem_weIn    (we[i]),
            .mem_rd_data (rd[i]),
            .stall       (stall[i]),
            .addr_err    (err[i])
        );
    end

    // Issue one request on instance k, hold it until stall drops, capture
    // the outputs in that completion cycle, then drop the request.
    task automatic do_access(input int k, input logic r, input logic w,
                             input logic [15:0] a, input logic [15:0] d,
                             output int nst, output logic [15:0] dout,
                             output logic derr);
        logic done;
        nst  = 0;
        dout = 'x;
        derr = 1'bx;
        done = 1'b0;
        @(posedge clk); #1;
        re[k] = r; we[k] = w; addr[k] = a; wdata[k] = d;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (stall[k]) nst++;
            else begin
                dout = rd[k];
                derr = err[k];
                done = 1'b1;
            end
        end
        if (!done) nst = -1;
        @(posedge clk); #1;
        re[k] = 1'b0; we[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (stall[k] !== 1'b0) begin
                $display("FAIL reset_stall[%0d]: got %b expected 0", k, stall[k]); n_err++;
            end
            n_vec++;
            if (err[k] !== 1'b0) begin
                $display("FAIL reset_err[%0d]: got %b expected 0", k, err[k]); n_err++;
            end
            if (k > 0) begin
                n_vec++;
                if (rd[k] !== 16'h0000) begin
                    $display("FAIL reset_rd[%0d]: got %h expected 0000", k, rd[k]); n_err++;
                end
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lat2_store_load();
        int nst; logic [15:0] d; logic e;
        do_access(2, 1'b0, 1'b1, 16'h0005, 16'hBEEF, nst, d, e);
        n_vec++;
        if (nst !== 2) begin $display("FAIL lat2_store_stall: got %0d expected 2", nst); n_err++; end
        n_vec++;
        if (e !== 1'b0) begin $display("FAIL lat2_store_err: got %b expected 0", e); n_err++; end
        do_access(2, 1'b1, 1'b0, 16'h0005, 16'h0000, nst, d, e);
        n_vec++;
        if (nst !== 2) begin $display("FAIL lat2_load_stall: got %0d expected 2", nst); n_err++; end
        n_vec++;
        if (d !== 16'hBEEF) begin $display("FAIL lat2_load_data: got %h expected beef", d); n_err++; end
    endtask

    task automatic test_lat0();
        int nst; logic [15:0] d; logic e;
        do_access(0, 1'b0, 1'b1, 16'h0003, 16'h1234, nst, d, e);
        n_vec++;
        if (nst !== 0) begin $display("FAIL lat0_store_stall: got %0d expected 0", nst); n_err++; end
        do_access(0, 1'b1, 1'b0, 16'h0003, 16'h0000, nst, d, e);
        n_vec++;
        if (nst !== 0) begin $display("FAIL lat0_load_stall: got %0d expected 0", nst); n_err++; end
        n_vec++;
        if (d !== 16'h1234) begin $display("FAIL lat0_load_data: got %h expected 1234", d); n_err++; end
        // Read-during-write of the same word shows the old contents
        do_access(0, 1'b1, 1'b1, 16'h0003, 16'h5678, nst, d, e);
        n_vec++;
        if (d !== 16'h1234) begin $display("FAIL lat0_rdw_old: got %h expected 1234", d); n_err++; end
        do_access(0, 1'b1, 1'b0, 16'h0003, 16'h0000, nst, d, e);
        n_vec++;
        if (d !== 16'h5678) begin $display("FAIL lat0_rdw_new: got %h expected 5678", d); n_err++; end
        do_access(0, 1'b1, 1'b0, 16'h0100, 16'h0000, nst, d, e);
        n_vec++;
        if (d !== 16'h0000) begin $display("FAIL lat0_oor_data: got %h expected 0000", d); n_err++; end
        n_vec++;
        if (e !== 1'b1) begin $display("FAIL lat0_oor_err: got %b expected 1", e); n_err++; end
    endtask

    task automatic test_both_enables();
        int nst; logic [15:0] d; logic e;
        do_access(3, 1'b0, 1'b1, 16'h0006, 16'h0F0F, nst, d, e);
        do_access(3, 1'b1, 1'b0, 16'h0006, 16'h0000, nst, d, e);
        n_vec++;
        if (d !== 16'h0F0F) begin $display("FAIL lat3_load_data: got %h expected 0f0f", d); n_err++; end
        do_access(3, 1'b1, 1'b1, 16'h0007, 16'hAAAA, nst, d, e);
        n_vec++;
        if (nst !== 3) begin $display("FAIL lat3_both_stall: got %0d expected 3", nst); n_err++; end
        n_vec++;
        if (d !== 16'h0F0F) begin $display("FAIL lat3_both_rdreg: got %h expected 0f0f", d); n_err++; end
        do_access(3, 1'b1, 1'b0, 16'h0007, 16'h0000, nst, d, e);
        n_vec++;
        if (d !== 16'hAAAA) begin $display("FAIL lat3_both_mem: got %h expected aaaa", d); n_err++; end
    endtask

    task automatic test_out_of_range();
        int nst; logic [15:0] d; logic e;
        do_access(2, 1'b0, 1'b1, 16'h0000, 16'h0123, nst, d, e);
        do_access(2, 1'b1, 1'b0, 16'h0100, 16'h0000, nst, d, e);
        n_vec++;
        if (d !== 16'h0000) begin $display("FAIL oor_load_data: got %h expected 0000", d); n_err++; end
        n_vec++;
        if (e !== 1'b1) begin $display("FAIL oor_load_err: got %b expected 1", e); n_err++; end
        @(negedge clk);
        n_vec++;
        if (err[2] !== 1'b0) begin $display("FAIL oor_err_pulse: got %b expected 0", err[2]); n_err++; end
        do_access(2, 1'b0, 1'b1, 16'h0100, 16'hFFFF, nst, d, e);
        n_vec++;
        if (e !== 1'b1) begin $display("FAIL oor_store_err: got %b expected 1", e); n_err++; end
        do_access(2, 1'b1, 1'b0, 16'h0000, 16'h0000, nst, d, e);
        n_vec++;
        if (d !== 16'h0123) begin $display("FAIL oor_word0_kept: got %h expected 0123", d); n_err++; end
        n_vec++;
        if (e !== 1'b0) begin $display("FAIL inrange_err: got %b expected 0", e); n_err++; end
        do_access(2, 1'b1, 1'b0, 16'h0005, 16'h0000, nst, d, e);
        n_vec++;
        if (d !== 16'hBEEF) begin $display("FAIL oor_word5_kept: got %h expected beef", d); n_err++; end
    endtask

    task automatic test_back_to_back();
        int nst; logic [15:0] d; logic e;
        logic [15:0] exp_b2b [3];
        exp_b2b = '{16'h0011, 16'h0022, 16'h0033};
        for (int j = 0; j < 3; j++) begin
            do_access(1, 1'b0, 1'b1, 16'(j + 1), exp_b2b[j], nst, d, e);
            n_vec++;
            if (nst !== 1) begin $display("FAIL lat1_store_stall[%0d]: got %0d expected 1", j, nst); n_err++; end
        end
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            re[1] = 1'b1; addr[1] = 16'(j + 1);
            @(negedge clk);
            n_vec++;
            if (stall[1] !== 1'b1) begin $display("FAIL b2b_stall_hi[%0d]: got %b expected 1", j, stall[1]); n_err++; end
            @(posedge clk); #1;
            @(negedge clk);
            n_vec++;
            if (stall[1] !== 1'b0) begin $display("FAIL b2b_stall_lo[%0d]: got %b expected 0", j, stall[1]); n_err++; end
            n_vec++;
            if (rd[1] !== exp_b2b[j]) begin $display("FAIL b2b_data[%0d]: got %h expected %h", j, rd[1], exp_b2b[j]); n_err++; end
            @(posedge clk); #1;
        end
        re[1] = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int nst; logic [15:0] d; logic e;
        do_access(4, 1'b0, 1'b1, 16'h0009, 16'h1111, nst, d, e);
        n_vec++;
        if (nst !== 4) begin $display("FAIL lat4_store_stall: got %0d expected 4", nst); n_err++; end
        @(posedge clk); #1;
        we[4] = 1'b1; addr[4] = 16'h0009; wdata[4] = 16'h5555;   // IDLE cycle
        @(posedge clk); #1;                                        // first WAIT
        @(posedge clk); #1;                                        // second WAIT
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (stall[4] !== 1'b1) begin $display("FAIL rstmid_pre_stall: got %b expected 1", stall[4]); n_err++; end
        @(posedge clk); #1;
        rst_n = 1'b1; we[4] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (stall[4] !== 1'b0) begin $display("FAIL rstmid_stall: got %b expected 0", stall[4]); n_err++; end
        do_access(4, 1'b1, 1'b0, 16'h0009, 16'h0000, nst, d, e);
        n_vec++;
        if (nst !== 4) begin $display("FAIL rstmid_load_stall: got %0d expected 4", nst); n_err++; end
        n_vec++;
        if (d !== 16'h1111) begin $display("FAIL rstmid_load_data: got %h expected 1111", d); n_err++; end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            re[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
        end
        test_reset();
        test_lat2_store_load();
        test_lat0();
        test_both_enables();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_stall_unit.md
Name: dmem_stall_unit

Overview:
- Data-memory block of the 16-bit pipelined CPU; sits directly upstream of the MEM stage write-back mux.
- Takes the ALU-computed address, store data and the memory read/write enables carried down from ID.
- Produces mem_rd_data for the MEM stage.
- Models a multi-cycle memory and asserts stall so the hazard logic freezes the pipeline until the access completes.

Parameters:
DEPTH, 256, number of 16-bit words; word addressed.
LATENCY, 2, access latency in cycles (0 = single-cycle combinational read, no stall).
CNT_W, 4, wait counter width; must satisfy 2^CNT_W > LATENCY.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  synchronous, active-low reset.
mem_addr  input  16  word address (the ALU result, dst_dataIn of MEM).
mem_wr_data  input  16  store data (mem_dataIn of MEM).
mem_reIn  input  1  load enable from ID.
mem_weIn  input  1  store enable from ID.
mem_rd_data  output  16  load data to the MEM write-back mux.
stall  output  1  high while an access is outstanding; pipeline holds all inputs stable.
addr_err  output  1  one-cycle pulse on the completion cycle of an out-of-range access.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, counter=0, rd_reg=16'h0000, addr_err=0. Memory contents are not cleared.
- Request: req = mem_reIn | mem_weIn. If both enables are high, the access is a write and no read data is updated.
- FSM states:
  - IDLE: stall = req && (LATENCY>0).
    - On req with LATENCY>=2: latch addr and data; go to WAIT with counter=LATENCY-2.
    - On req with LATENCY==1: perform the access at this edge; go to DONE.
  - WAIT: stall=1.
    - If counter==0: perform the access at this edge; go to DONE.
    - Otherwise decrement the counter and stay in WAIT.
  - DONE: stall=0; mem_rd_data=rd_reg; inputs are ignored (they still show the retiring request); go unconditionally to IDLE.
- Timing: a request first seen in IDLE at cycle T has stall high for cycles T..T+LATENCY-1. DONE is cycle T+LATENCY, in which the pipeline advances.
- "Perform access":
  - Read: rd_reg <= mem[addr].
  - Write: mem[addr] <= data.
  - Both use the values latched in IDLE, not the live inputs.
- LATENCY==0: no FSM activity and stall is always 0.
  - mem_rd_data is a combinational read of mem[mem_addr].
  - A write commits at the edge ending the request cycle.
  - A read of the address being written in the same cycle returns the old contents.
- Out of range (latched addr >= DEPTH): the read returns 16'h0000 and the write is dropped. addr_err pulses high in DONE, or in the request cycle when LATENCY==0.
- mem_rd_data outside DONE (LATENCY>0): holds rd_reg, with the last value retained. Consumers must use it only in DONE.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE, giving a throughput of one access per LATENCY+1 cycles.
- Reset mid-access: FSM returns to IDLE and stall drops next cycle. A write not yet performed is abandoned and memory is unchanged.

Decomposition:
- Shared cpu_pkg constants: WORD_W=16, state encodings DM_IDLE/DM_WAIT/DM_DONE, RD_DEFAULT=16'h0000.
- One natural sub-module: dmem_array. It holds the DEPTH x 16 storage with a synchronous write port and an asynchronous read port. dmem_stall_unit wraps it with the FSM, latches and range check.

Test Plan:
1. LATENCY=2, reset, then store addr 16'h0005 data 16'hBEEF → stall high 2 cycles, low in DONE; a later load of addr 5 → stall 2 cycles, mem_rd_data=16'hBEEF in DONE.
2. LATENCY=0, store 16'h1234 to addr 3, next cycle load addr 3 → stall never asserted; mem_rd_data=16'h1234 combinationally in the load cycle.
3. LATENCY=3, mem_reIn and mem_weIn both high, addr 7, data 16'hAAAA → treated as write; mem[7]=16'hAAAA; rd_reg keeps its prior value.
4. DEPTH=256, load addr 16'h0100 → mem_rd_data=16'h0000 in DONE, addr_err one-cycle pulse; store to 16'h0100 leaves all words unchanged.
5. LATENCY=4, store addr 9 data 16'h5555, rst_n low in the second WAIT cycle → next cycle stall=0, state IDLE; a later load of addr 9 returns the pre-store value.
6. LATENCY=1, three back-to-back loads (addrs 1,2,3 preloaded 16'h0011/0022/0033) → stall pattern 1,0(DONE),1,0,1,0 over the load cycles; data delivered in DONE cycles in order.
